// File: rtl/sd_dat_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sd_dat_rx                                                  |
// | Description : SD 4-bit DAT line block receiver writing nibbles to RAM,   |
// |               with end-bit check and optional per-line CRC16 check.      |
// | Option      : define SD_DAT_RX_CRC_EN to build the CRC16 check logic.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module sd_dat_rx #(
  parameter int addr_width   = 10,
  parameter int timeout_bits = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  bit_en,
  input  logic [3:0]            dat_in,
  output logic                  write_en,
  output logic [addr_width-1:0] waddr,
  output logic [3:0]            din,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_fail,
  output logic                  end_err,
  output logic                  timeout
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_DATA       = 3'd2,
    S_CRC        = 3'd3,
    S_END_BIT    = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [addr_width-1:0]   c_last_addr = '1;
  localparam logic [timeout_bits-1:0] c_wait_max  = '1;

  state_t                  r_state;
  logic [addr_width-1:0]   r_nib_cnt;
  logic [timeout_bits-1:0] r_wait_cnt;
  logic [3:0]              r_crc_cnt;
  logic                    r_end_bad;
  logic                    r_write_en;
  logic [addr_width-1:0]   r_waddr;
  logic [3:0]              r_din;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_end_err;
  logic                    r_timeout;
  logic                    w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_nib_cnt  <= '0;
      r_wait_cnt <= '0;
      r_crc_cnt  <= '0;
      r_end_bad  <= 1'b0;
      r_write_en <= 1'b0;
      r_waddr    <= '0;
      r_din      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_end_err  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_write_en <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_WAIT_START;
            r_busy     <= 1'b1;
            r_nib_cnt  <= '0;
            r_wait_cnt <= '0;
            r_crc_cnt  <= '0;
            r_end_bad  <= 1'b0;
            r_end_err  <= 1'b0;
          end
        end
        S_WAIT_START: begin
          if (bit_en) begin
            if (dat_in == 4'h0) begin
              r_state <= S_DATA;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
              // The increment about to land on the all-ones value ends the wait
              if (r_wait_cnt == c_wait_max - 1'b1) begin
                r_timeout <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= S_IDLE;
              end
            end
          end
        end
        S_DATA: begin
          if (bit_en) begin
            r_write_en <= 1'b1;
            r_waddr    <= r_nib_cnt;
            r_din      <= dat_in;
            if (r_nib_cnt == c_last_addr) begin
              r_state <= S_CRC;
            end else begin
              r_nib_cnt <= r_nib_cnt + 1'b1;
            end
          end
        end
        S_CRC: begin
          if (bit_en) begin
            r_crc_cnt <= r_crc_cnt + 1'b1;
            if (r_crc_cnt == 4'hF) begin
              r_state <= S_END_BIT;
            end
          end
        end
        S_END_BIT: begin
          if (bit_en) begin
            r_end_bad <= (dat_in != 4'hF);
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done    <= 1'b1;
          r_end_err <= r_end_bad;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign write_en = r_write_en;
  assign waddr    = r_waddr;
  assign din      = r_din;
  assign busy     = r_busy;
  assign done     = r_done;
  assign end_err  = r_end_err;
  assign timeout  = r_timeout;

`ifdef SD_DAT_RX_CRC_EN
  localparam logic [15:0] c_poly = 16'h1021;

  logic [3:0] w_line_bad;
  logic       r_crc_fail;

  for (genvar l = 0; l < 4; l++) begin : g_line
    logic [15:0] r_calc;
    logic [15:0] r_rx;

    always_ff @(posedge clk) begin
      if (rst || w_accept) begin
        r_calc <= '0;
        r_rx   <= '0;
      end else if (bit_en && (r_state == S_DATA)) begin
        r_calc <= {r_calc[14:0], 1'b0} ^ ({16{r_calc[15] ^ dat_in[l]}} & c_poly);
      end else if (bit_en && (r_state == S_CRC)) begin
        r_rx <= {r_rx[14:0], dat_in[l]};
      end
    end

    assign w_line_bad[l] = (r_calc != r_rx);
  end

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_crc_fail <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_crc_fail <= |w_line_bad;
    end
  end

  assign crc_fail = r_crc_fail;
`else
  assign crc_fail = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sd_dat_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sd_dat_rx                                               |
// | Description : Frame-level reference bench for sd_dat_rx.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_sd_dat_rx;

  localparam int AW = 10;
  localparam int TB = 4;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          bit_en = 1'b0;
  logic [3:0]    dat_in = 4'h0;
  logic          write_en;
  logic [AW-1:0] waddr;
  logic [3:0]    din;
  logic          busy;
  logic          done;
  logic          crc_fail;
  logic          end_err;
  logic          timeout;

  always #5 clk = ~clk;

  sd_dat_rx #(.addr_width(AW), .timeout_bits(TB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bit_en   (bit_en),
    .dat_in   (dat_in),
    .write_en (write_en),
    .waddr    (waddr),
    .din      (din),
    .busy     (busy),
    .done     (done),
    .crc_fail (crc_fail),
    .end_err  (end_err),
    .timeout  (timeout)
  );

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;
  int gmin       = 0;
  int gmax       = 0;

  // expected outputs after the next clock edge
  logic          e_we, e_done, e_to, e_busy, e_crc, e_end, e_chkaddr;
  logic [AW-1:0] e_waddr;
  logic [3:0]    e_din;
  // frame-level model state
  logic          m_busy = 1'b0;
  logic          m_crc  = 1'b0;
  logic          m_end  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // CRC as remainder of M(x)*x^16 mod G(x) by long division
  function automatic logic [15:0] crc_of(input bit msg[$]);
    logic [16:0] r = '0;
    bit m[$] = msg;
    for (int k = 0; k < 16; k++) m.push_back(1'b0);
    foreach (m[k]) begin
      r = {r[15:0], m[k]};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("write_en", write_en, e_we);
      if (e_we || e_chkaddr) begin
        chk("waddr", waddr, e_waddr);
        chk("din", din, e_din);
      end
      chk("done", done, e_done);
      chk("timeout", timeout, e_to);
      chk("busy", busy, e_busy);
      chk("crc_fail", crc_fail, e_crc);
      chk("end_err", end_err, e_end);
    end
  end

  task automatic tick(input logic st, input logic be, input logic [3:0] d, input logic r,
                      input logic xwe, input int xaddr, input logic [3:0] xdin,
                      input logic xdone, input logic xto);
    start = st; bit_en = be; dat_in = d; rst = r;
    e_we = xwe; e_waddr = xaddr[AW-1:0]; e_din = xdin; e_done = xdone; e_to = xto;
    e_chkaddr = r; e_busy = m_busy; e_crc = m_crc; e_end = m_end;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 4'($urandom), 1'b0, 1'b0, 0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic strobe(input logic [3:0] d, input logic st, input logic xwe, input int xaddr);
    quiet(int'($urandom_range(gmax, gmin)));
    tick(st, 1'b1, d, 1'b0, xwe, xaddr, d, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input int n_idle, input int mingap, input int maxgap, input bit pattern,
                           input bit flip, input int flip_line, input int flip_bit,
                           input logic [3:0] end_nib, input int start_at, input int rst_after);
    logic [3:0]  data [];
    logic [15:0] crc [4];
    bit          q[$];
    gmin = mingap; gmax = maxgap;
    data = new[N];
    for (int i = 0; i < N; i++) data[i] = pattern ? 4'(i) : 4'($urandom);
    for (int l = 0; l < 4; l++) begin
      q = {};
      for (int i = 0; i < N; i++) q.push_back(data[i][l]);
      crc[l] = crc_of(q);
    end
    m_busy = 1'b1; m_crc = 1'b0; m_end = 1'b0;
    tick(1'b1, 1'($urandom), 4'($urandom), 1'b0, 1'b0, 0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < n_idle; k++) strobe(4'hF, 1'b0, 1'b0, 0);
    strobe(4'h0, 1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) begin
      strobe(data[i], (i == start_at), 1'b1, i);
      if (i + 1 == rst_after) begin
        m_busy = 1'b0; m_crc = 1'b0; m_end = 1'b0;
        tick(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) strobe(4'($urandom), 1'b0, 1'b0, 0);
        return;
      end
    end
    for (int j = 15; j >= 0; j--) begin
      logic [3:0] n;
      for (int l = 0; l < 4; l++) n[l] = crc[l][j] ^ (flip && (l == flip_line) && (j == flip_bit));
      strobe(n, 1'b0, 1'b0, 0);
    end
    strobe(end_nib, 1'b0, 1'b0, 0);
`ifdef SD_DAT_RX_CRC_EN
    m_crc = flip;
`else
    m_crc = 1'b0;
`endif
    m_end  = (end_nib != 4'hF);
    m_busy = 1'b0;
    tick(1'b0, 1'($urandom), 4'($urandom), 1'b0, 1'b0, 0, 4'h0, 1'b1, 1'b0);
    quiet(2);
  endtask

  initial begin
    bit         q[$];
    logic [7:0] s [9];
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    // pin the reference CRC against known values
    q = {};
    foreach (s[i]) for (int b = 7; b >= 0; b--) q.push_back(s[i][b]);
    chk("crc_pin_123456789", crc_of(q), 32'h31C3);
    q = {1'b1};
    chk("crc_pin_single_one", crc_of(q), 32'h1021);
    q = {};
    for (int b = 0; b < 8; b++) q.push_back(1'b0);
    chk("crc_pin_zero_byte", crc_of(q), 32'h0000);

    chk_en = 1'b1;
    tick(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
    quiet(3);

    // nominal block, bit_en every cycle
    run_frame(3, 0, 0, 1'b1, 1'b0, 0, 0, 4'hF, -1, -1);
    // CRC bit 0 of DAT2 flipped
    run_frame(3, 0, 3, 1'b1, 1'b1, 2, 0, 4'hF, -1, -1);
    // bad end nibble
    run_frame(3, 0, 2, 1'b1, 1'b0, 0, 0, 4'h7, -1, -1);

    // start-bit timeout after 15 strobes
    m_busy = 1'b1; m_crc = 1'b0; m_end = 1'b0;
    tick(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 0, 4'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) m_busy = 1'b0;
      tick(1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 0, 4'h0, 1'b0, (k == 15));
    end
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 0, 4'h0, 1'b0, 1'b0);

    // reset after the 500th nibble, then a full block
    run_frame(3, 0, 1, 1'b1, 1'b0, 0, 0, 4'hF, -1, 500);
    run_frame(3, 0, 1, 1'b1, 1'b0, 0, 0, 4'hF, -1, -1);
    // bit_en every third clock with a stray start during data
    run_frame(3, 2, 2, 1'b1, 1'b0, 0, 0, 4'hF, 300, -1);

    // randomized blocks
    for (int f = 0; f < 3; f++) begin
      run_frame(int'($urandom_range(12, 0)), 0, 3, 1'b0, 1'($urandom),
                int'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
                ($urandom % 2) ? 4'hF : 4'($urandom), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
